noc_output_arbiter: RTL

Per-output-port wormhole arbiter for the NoC router. Each router has five instances, one per output direction (north, south, west, east, local). Each instance takes the 3-bit route codes produced by the YX route computation of all five input ports. It grants the output port to one requesting input, round-robin, and holds the grant for the whole packet until the tail flit has transferred. It drives the crossbar select and the pop strobes back to the input FIFOs.

---
 rtl/noc_output_arbiter.sv | 79 +++++++
 1 files changed

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: round-robin wormhole arbiter for one router output port
module noc_output_arbiter #(
   parameter logic [2:0] PORT_ID = 3'b000,
   parameter int NUM_IN = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NUM_IN-1:0]     req_valid_i,
   input  logic [3*NUM_IN-1:0]   req_dir_i,
   input  logic [NUM_IN-1:0]     req_tail_i,
   input  logic                  out_ready_i,
   output logic [NUM_IN-1:0]     grant_o,
   output logic [2:0]            sel_o,
   output logic                  out_valid_o,
   output logic [NUM_IN-1:0]     pop_o,
   output logic                  busy_o,
   output logic [15:0]           pkt_cnt_o
);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t state, state_nx;
   logic [2:0] rr_ptr, rr_nx, sel_nx, win, j;
   logic [NUM_IN-1:0] req, grant_nx;
   logic [15:0] cnt_nx;
   logic found, tail_xfer;
   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_IN; i++) req[i] = req_valid_i[i] && req_dir_i[3*i +: 3] == PORT_ID;
   end
   // search starts just above the last served input, so it becomes lowest priority
   always_comb begin
      found = 1'b0;
      win = '0;
      j = '0;
      for (int k = 1; k <= NUM_IN; k++) begin
         j = 3'((int'(rr_ptr) + k) % NUM_IN);
         if (!found && req[j]) begin
            found = 1'b1;
            win = j;
         end
      end
   end
   assign pop_o = grant_o & req_valid_i & {NUM_IN{out_ready_i}};
   assign out_valid_o = |(grant_o & req_valid_i);
   assign tail_xfer = |(pop_o & req_tail_i);
   assign busy_o = state == LOCKED;
   always_comb begin
      state_nx = state;
      grant_nx = grant_o;
      sel_nx = sel_o;
      rr_nx = rr_ptr;
      cnt_nx = pkt_cnt_o;
      if (state == IDLE && found) begin
         state_nx = LOCKED;
         grant_nx = NUM_IN'(1) << win;
         sel_nx = win;
      end else if (state == LOCKED && tail_xfer) begin
         state_nx = IDLE;
         grant_nx = '0;
         sel_nx = '0;
         rr_nx = sel_o;
         cnt_nx = pkt_cnt_o + 16'd1;
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         grant_o <= '0;
         sel_o <= '0;
         rr_ptr <= 3'(NUM_IN - 1);
         pkt_cnt_o <= '0;
      end else begin
         state <= state_nx;
         grant_o <= grant_nx;
         sel_o <= sel_nx;
         rr_ptr <= rr_nx;
         pkt_cnt_o <= cnt_nx;
      end
   end
endmodule
